// File: rtl/cache_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter_if
//
// Purpose : bundles the requester-side and cache-side signals of the cache
//           request arbiter into one interface.
//
// Signals :
//   req_i       per-requester request, held with its address until granted
//   addr_i      per-requester address, slice k belongs to requester k
//   gnt_o       one-hot address-accept strobe
//   rvalid_o    one-hot, single-cycle read-return strobe
//   rdata_o     read word, valid while any rvalid_o bit is set
//   rerr_o      qualifies rvalid_o: 1 = the cache timed out
//   busy_o      arbiter is not idle
//   cache_req   request to the cache, held until cache_valid
//   cache_addr  address presented to the cache
//   cache_valid cache data-ready
//   cache_data  cache read data
//
// Modports:
//   master : the arbiter itself (it masters the cache port)
//   slave  : the environment (requesters plus the cache)
// ---------------------------------------------------------------------------
interface cache_req_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32
);

    // Requester side
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [WORD_WIDTH-1:0]         rdata_o;
    logic                          rerr_o;
    logic                          busy_o;

    // Cache side
    logic                          cache_req;
    logic [ADDR_WIDTH-1:0]         cache_addr;
    logic                          cache_valid;
    logic [WORD_WIDTH-1:0]         cache_data;

    modport master (
        input  req_i,
        input  addr_i,
        output gnt_o,
        output rvalid_o,
        output rdata_o,
        output rerr_o,
        output busy_o,
        output cache_req,
        output cache_addr,
        input  cache_valid,
        input  cache_data
    );

    modport slave (
        output req_i,
        output addr_i,
        input  gnt_o,
        input  rvalid_o,
        input  rdata_o,
        input  rerr_o,
        input  busy_o,
        input  cache_req,
        input  cache_addr,
        output cache_valid,
        output cache_data
    );

endinterface : cache_req_arbiter_if

// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter
//
// Purpose : shares the single CPU-side port of the cache among NUM_REQ
//           requesters. Round-robin grant, one outstanding access at a time.
//           Sequences the cache handshake, returns the read word to the
//           granted requester and reports an error when the cache fails to
//           answer within TIMEOUT_CYCLES busy cycles (0 disables the timeout).
//
// Ports   :
//   clk   clock, all state changes on posedge
//   rst   synchronous active-high reset
//   bus   cache_req_arbiter_if.master, requester and cache signals
//
// Sequencing: IDLE -> BUSY -> GAP -> IDLE. The GAP cycle carries the read
// return and drops cache_req so the cache can clear its valid before the
// next access can be granted.
// ---------------------------------------------------------------------------
module cache_req_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_req_arbiter_if.master   bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [CNT_W-1:0] CNT_LIMIT = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [PTR_W-1:0] PTR_INIT  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one       = {{(NUM_REQ-1){1'b0}}, 1'b1};
        to_onehot = one << idx;
    endfunction

    // Registered state
    state_t                 state_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   cache_req_q;
    logic [ADDR_WIDTH-1:0]  cache_addr_q;
    logic [NUM_REQ-1:0]     rvalid_q;
    logic [WORD_WIDTH-1:0]  rdata_q;
    logic                   rerr_q;

    // Arbitration results
    logic                   win_valid_s;
    logic [PTR_W-1:0]       win_idx_s;
    logic [NUM_REQ-1:0]     gnt_s;
    logic                   timeout_s;

    // Round-robin scan: first requester after the last grant, wrapping.
    always_comb begin : arb_scan
        int idx;
        idx         = 0;
        win_valid_s = 1'b0;
        win_idx_s   = {PTR_W{1'b0}};
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = (int'(ptr_q) + i) % int'(NUM_REQ);
            if (!win_valid_s && bus.req_i[idx]) begin
                win_valid_s = 1'b1;
                win_idx_s   = PTR_W'(idx);
            end else begin
                // an earlier candidate already won, or this one is not requesting
                win_valid_s = win_valid_s;
            end
        end
    end

    // Grant strobe: only in IDLE and never while reset is asserted.
    always_comb begin
        gnt_s = {NUM_REQ{1'b0}};
        if ((state_q == ST_IDLE) && !rst && win_valid_s) begin
            gnt_s = to_onehot(win_idx_s);
        end else begin
            gnt_s = {NUM_REQ{1'b0}};
        end
    end

    // Timeout fires on the busy cycle whose pre-increment count is the limit.
    always_comb begin
        timeout_s = 1'b0;
        if (TO_EN && (cnt_q == CNT_LIMIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Access sequencer FSM with registered cache-side and return outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_INIT;
            cnt_q        <= {CNT_W{1'b0}};
            cache_req_q  <= 1'b0;
            cache_addr_q <= {ADDR_WIDTH{1'b0}};
            rvalid_q     <= {NUM_REQ{1'b0}};
            rdata_q      <= {WORD_WIDTH{1'b0}};
            rerr_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rvalid_q <= {NUM_REQ{1'b0}};
                    rerr_q   <= 1'b0;
                    if (win_valid_s) begin
                        cache_addr_q <= bus.addr_i[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                        cache_req_q  <= 1'b1;
                        ptr_q        <= win_idx_s;
                        cnt_q        <= {CNT_W{1'b0}};
                        state_q      <= ST_BUSY;
                    end else begin
                        cache_req_q  <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end

                ST_BUSY: begin
                    // Data from the cache takes precedence over a simultaneous timeout.
                    if (bus.cache_valid) begin
                        rdata_q     <= bus.cache_data;
                        rvalid_q    <= to_onehot(ptr_q);
                        rerr_q      <= 1'b0;
                        cache_req_q <= 1'b0;
                        state_q     <= ST_GAP;
                    end else begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_q <= cnt_q;
                        end
                        if (timeout_s) begin
                            rdata_q     <= {WORD_WIDTH{1'b0}};
                            rvalid_q    <= to_onehot(ptr_q);
                            rerr_q      <= 1'b1;
                            cache_req_q <= 1'b0;
                            state_q     <= ST_GAP;
                        end else begin
                            rvalid_q    <= {NUM_REQ{1'b0}};
                            rerr_q      <= 1'b0;
                            cache_req_q <= 1'b1;
                            state_q     <= ST_BUSY;
                        end
                    end
                end

                ST_GAP: begin
                    // rdata_q holds; only the strobes are cleared.
                    rvalid_q    <= {NUM_REQ{1'b0}};
                    rerr_q      <= 1'b0;
                    cache_req_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    rvalid_q    <= {NUM_REQ{1'b0}};
                    rerr_q      <= 1'b0;
                    cache_req_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o      = gnt_s;
    assign bus.rvalid_o   = rvalid_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.rerr_o     = rerr_q;
    assign bus.busy_o     = (state_q != ST_IDLE);
    assign bus.cache_req  = cache_req_q;
    assign bus.cache_addr = cache_addr_q;

endmodule : cache_req_arbiter

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_cache_req_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned TO = 8;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    cache_req_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    cache_req_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .WORD_WIDTH     (WW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Full access: grant in IDLE, cache answers after k cycles of cache_req.
    task automatic access(input string tag, input logic [1:0] req_v, input logic [1:0] exp_gnt,
                          input logic [31:0] exp_addr, input int k, input logic [31:0] data);
        bus.req_i = req_v;
        #1;
        chk({tag, ".gnt"}, bus.gnt_o, exp_gnt);
        step();
        chk({tag, ".creq"}, bus.cache_req, 1'b1);
        chk({tag, ".caddr"}, bus.cache_addr, exp_addr);
        chk({tag, ".gnt_busy"}, bus.gnt_o, 2'b00);
        repeat (k - 1) step();
        bus.cache_valid = 1'b1;
        bus.cache_data  = data;
        step();
        bus.cache_valid = 1'b0;
        chk({tag, ".rvalid"}, bus.rvalid_o, exp_gnt);
        chk({tag, ".rdata"}, bus.rdata_o, data);
        chk({tag, ".rerr"}, bus.rerr_o, 1'b0);
        chk({tag, ".creq_gap"}, bus.cache_req, 1'b0);
        step();
        chk({tag, ".rvalid_end"}, bus.rvalid_o, 2'b00);
        chk({tag, ".busy_end"}, bus.busy_o, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst             = 1'b1;
        bus.req_i       = 2'b11;
        bus.addr_i      = '0;
        bus.cache_valid = 1'b0;
        bus.cache_data  = '0;

        // 1: reset with both requesting
        step();
        chk("rst.gnt", bus.gnt_o, 2'b00);
        chk("rst.creq", bus.cache_req, 1'b0);
        step();
        chk("rst.gnt2", bus.gnt_o, 2'b00);
        chk("rst.creq2", bus.cache_req, 1'b0);
        chk("rst.rvalid", bus.rvalid_o, 2'b00);
        chk("rst.busy", bus.busy_o, 1'b0);
        bus.req_i = 2'b00;
        rst       = 1'b0;
        step();

        // 2: single read from requester 0, cache answers 3 cycles after cache_req
        bus.addr_i = {32'h0000_0000, 32'h0000_0040};
        access("single", 2'b01, 2'b01, 32'h40, 3, 32'hDEAD_BEEF);
        bus.req_i = 2'b00;

        // 3: round-robin from a fresh reset, both held
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.addr_i = {32'h0000_0020, 32'h0000_0010};
        access("rr0", 2'b11, 2'b01, 32'h10, 1, 32'h1111_0000);
        access("rr1", 2'b11, 2'b10, 32'h20, 2, 32'h2222_0000);
        access("rr2", 2'b11, 2'b01, 32'h10, 1, 32'h3333_0000);
        access("rr3", 2'b11, 2'b10, 32'h20, 4, 32'h4444_0000);
        bus.req_i = 2'b00;
        step();

        // 4: timeout, requester 0, cache never answers
        bus.addr_i = {32'h0000_0000, 32'h0000_0080};
        bus.req_i  = 2'b01;
        #1;
        chk("to.gnt", bus.gnt_o, 2'b01);
        step();
        bus.req_i = 2'b00;
        chk("to.creq", bus.cache_req, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to.wait_rvalid", bus.rvalid_o, 2'b00);
        end
        chk("to.wait_creq", bus.cache_req, 1'b1);
        step();
        chk("to.rvalid", bus.rvalid_o, 2'b01);
        chk("to.rerr", bus.rerr_o, 1'b1);
        chk("to.rdata", bus.rdata_o, 32'h0);
        chk("to.creq_low", bus.cache_req, 1'b0);
        step();
        chk("to.rvalid_end", bus.rvalid_o, 2'b00);
        chk("to.rerr_end", bus.rerr_o, 1'b0);

        // 5: cache_valid arrives on the limit cycle, then stays high
        bus.addr_i = {32'h0000_00C0, 32'h0000_0000};
        bus.req_i  = 2'b10;
        #1;
        chk("race.gnt", bus.gnt_o, 2'b10);
        step();
        bus.req_i = 2'b00;
        repeat (7) step();
        chk("race.pre_rvalid", bus.rvalid_o, 2'b00);
        bus.cache_valid = 1'b1;
        bus.cache_data  = 32'h1234_5678;
        step();
        chk("race.rvalid", bus.rvalid_o, 2'b10);
        chk("race.rerr", bus.rerr_o, 1'b0);
        chk("race.rdata", bus.rdata_o, 32'h1234_5678);
        step();
        chk("race.gap_rvalid", bus.rvalid_o, 2'b00);
        step();
        chk("race.idle_rvalid", bus.rvalid_o, 2'b00);
        chk("race.idle_busy", bus.busy_o, 1'b0);
        chk("race.idle_creq", bus.cache_req, 1'b0);
        chk("race.rdata_hold", bus.rdata_o, 32'h1234_5678);
        bus.cache_valid = 1'b0;

        // 6: reset in the middle of BUSY
        bus.req_i = 2'b10;
        #1;
        chk("mid.gnt", bus.gnt_o, 2'b10);
        step();
        bus.req_i = 2'b00;
        step();
        chk("mid.creq_busy", bus.cache_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid.creq", bus.cache_req, 1'b0);
        chk("mid.busy", bus.busy_o, 1'b0);
        chk("mid.rvalid", bus.rvalid_o, 2'b00);
        bus.cache_valid = 1'b1;
        step();
        chk("mid.rvalid2", bus.rvalid_o, 2'b00);
        bus.cache_valid = 1'b0;
        bus.req_i = 2'b11;
        #1;
        chk("mid.gnt_after", bus.gnt_o, 2'b01);
        step();
        chk("mid.caddr_after", bus.cache_addr, 32'h0);
        bus.req_i = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cache_req_arbiter
